// File: rtl/convo_relu_maxpool.sv
// ReLU with 8-bit saturation followed by 2x2 stride-2 max pooling over a raster-order
// convolution sample stream; emits one pooled pixel per completed 2x2 window.
module convo_relu_maxpool #(
  parameter int unsigned N     = 10,
  parameter int unsigned IN_W  = 13,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  conv_in,
  input  logic             conv_valid,
  output logic [OUT_W-1:0] pool_out,
  output logic             pool_valid,
  output logic             pool_last,
  output logic             frame_busy
);

  localparam int unsigned M    = N - 2;
  localparam int unsigned Half = M / 2;
  localparam int unsigned CW   = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned BW   = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(M - 1);

  logic [CW-1:0]    col_q, col_d, row_q, row_d;
  logic [OUT_W-1:0] held_q, held_d;
  logic [OUT_W-1:0] row_buf_q [Half];
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d, last_q, last_d, busy_q, busy_d;

  logic [OUT_W-1:0] relu, pair_max, buf_rd, pool_max;
  logic [BW-1:0]    buf_idx;
  logic             col_last, row_last, buf_we;

  // Negative -> 0; anything above the unsigned output range clips to all-ones.
  always_comb begin
    relu = conv_in[OUT_W-1:0];
    if (conv_in[IN_W-1]) begin
      relu = '0;
    end else if (|conv_in[IN_W-2:OUT_W]) begin
      relu = '1;
    end
  end

  assign buf_idx  = BW'(col_q >> 1);
  assign buf_rd   = row_buf_q[buf_idx];
  assign pair_max = (held_q > relu) ? held_q : relu;
  assign pool_max = (buf_rd > pair_max) ? buf_rd : pair_max;
  assign col_last = (col_q == LastIdx);
  assign row_last = (row_q == LastIdx);
  assign buf_we   = conv_valid && col_q[0] && !row_q[0];

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    held_d  = held_q;
    out_d   = out_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    busy_d  = busy_q;
    if (conv_valid) begin
      busy_d = 1'b1;
      if (!col_q[0]) begin
        held_d = relu;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (col_q[0] && row_q[0]) begin
        out_d   = pool_max;
        valid_d = 1'b1;
        last_d  = col_last && row_last;
      end
      // Busy drops in the same cycle the final pixel is presented.
      if (col_last && row_last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      held_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      held_q  <= held_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Row buffer contents are fully rewritten by each even row before being read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      row_buf_q[buf_idx] <= pair_max;
    end
  end

  assign pool_out   = out_q;
  assign pool_valid = valid_q;
  assign pool_last  = last_q;
  assign frame_busy = busy_q;

endmodule
